// File: rtl/tdm_demux.sv
// tdm_demux: distributes a framed TDM sample stream into per-channel holding registers
module tdm_demux #(
  parameter int CH = 2,
  parameter int DW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    din,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic [CH*DW-1:0] ch_out,
  output logic [CH-1:0]    ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);
  localparam int SW = $clog2(CH);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t state;
  logic [SW-1:0] slot;
  assign locked = (state == LOCK);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= '0;
      ch_out     <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (in_valid) begin
        if (frame_sync) begin
          // a sync beat always restarts the frame; arriving mid-frame it is an early sync
          ch_out[0 +: DW] <= din;
          ch_valid[0]     <= 1'b1;
          slot            <= SW'(1);
          sync_err        <= (state == LOCK) && (slot != '0);
          state           <= LOCK;
        end else if (state == LOCK) begin
          if (slot == '0) begin
            sync_err <= 1'b1;
            state    <= HUNT;
          end else begin
            ch_out[int'(slot)*DW +: DW] <= din;
            ch_valid[slot]              <= 1'b1;
            frame_done                  <= (slot == SW'(CH-1));
            slot                        <= (slot == SW'(CH-1)) ? '0 : slot + 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed vector and sequence checks for tdm_demux (CH=2 and CH=4 instances)
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] din2 = '0, din4 = '0;
  logic v2 = 1'b0, fs2 = 1'b0, v4 = 1'b0, fs4 = 1'b0;
  logic [3:0] co2;
  logic [1:0] cv2;
  logic fd2, lk2, se2;
  logic [7:0] co4;
  logic [3:0] cv4;
  logic fd4, lk4, se4;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  tdm_demux #(.CH(2), .DW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .in_valid(v2), .frame_sync(fs2),
    .ch_out(co2), .ch_valid(cv2), .frame_done(fd2), .locked(lk2), .sync_err(se2)
  );

  tdm_demux #(.CH(4), .DW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .in_valid(v4), .frame_sync(fs4),
    .ch_out(co4), .ch_valid(cv4), .frame_done(fd4), .locked(lk4), .sync_err(se4)
  );

  typedef struct {
    logic v, fs;
    logic [1:0] d;
    logic [3:0] co;
    logic [1:0] cv;
    logic fd, lk, se;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step2(input logic v, input logic fs, input logic [1:0] d);
    @(negedge clk);
    v2 = v; fs2 = fs; din2 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic fs, input logic [1:0] d);
    @(negedge clk);
    v4 = 1'b1; fs4 = fs; din4 = d;
    @(posedge clk);
    #1;
    v4 = 1'b0;
  endtask

  task automatic chk2(input string name, input logic [3:0] co, input logic [1:0] cv,
                      input logic fd, input logic lk, input logic se);
    chk({name, ".ch_out"}, 32'(co2), 32'(co));
    chk({name, ".ch_valid"}, 32'(cv2), 32'(cv));
    chk({name, ".frame_done"}, 32'(fd2), 32'(fd));
    chk({name, ".locked"}, 32'(lk2), 32'(lk));
    chk({name, ".sync_err"}, 32'(se2), 32'(se));
  endtask

  task automatic chk4(input string name, input logic [7:0] co, input logic [3:0] cv,
                      input logic fd, input logic lk, input logic se);
    chk({name, ".ch_out"}, 32'(co4), 32'(co));
    chk({name, ".ch_valid"}, 32'(cv4), 32'(cv));
    chk({name, ".frame_done"}, 32'(fd4), 32'(fd));
    chk({name, ".locked"}, 32'(lk4), 32'(lk));
    chk({name, ".sync_err"}, 32'(se4), 32'(se));
  endtask

  initial begin
    logic [3:0] m;
    logic [2:0] fb;
    // lock, gaps, missing sync then relock
    tbl[0]  = '{1'b1, 1'b0, 2'b01, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'b10, 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b11, 4'b1110, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 4'b1110, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'b00, 4'b1100, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'b11, 4'b1100, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'b11, 4'b1100, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'b01, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 2'b10, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 2'b01, 4'b1101, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 2'b10, 4'b1001, 2'b10, 1'b1, 1'b1, 1'b0};

    #12;
    chk2("reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk4("reset4", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step2(tbl[i].v, tbl[i].fs, tbl[i].d);
      chk2($sformatf("vec%0d", i), tbl[i].co, tbl[i].cv, tbl[i].fd, tbl[i].lk, tbl[i].se);
    end

    // back-to-back sweep: every din value lands in both slots
    m = 4'b1001;
    for (int f = 0; f < 8; f++) begin
      fb = 3'(f);
      m[1:0] = fb[1:0];
      step2(1'b1, 1'b1, fb[1:0]);
      chk2($sformatf("sweep%0d.s0", f), m, 2'b01, 1'b0, 1'b1, 1'b0);
      m[3:2] = fb[2:1];
      step2(1'b1, 1'b0, fb[2:1]);
      chk2($sformatf("sweep%0d.s1", f), m, 2'b10, 1'b1, 1'b1, 1'b0);
    end
    v2 = 1'b0;

    // early sync on the CH=4 instance at slot 2
    step4(1'b1, 2'b01);
    step4(1'b0, 2'b10);
    step4(1'b0, 2'b11);
    step4(1'b0, 2'b01);
    chk4("ch4.full", 8'b01_11_10_01, 4'b1000, 1'b1, 1'b1, 1'b0);
    step4(1'b1, 2'b10);
    step4(1'b0, 2'b00);
    step4(1'b1, 2'b11);
    chk4("ch4.early", 8'b01_11_00_11, 4'b0001, 1'b0, 1'b1, 1'b1);
    step4(1'b0, 2'b10);
    chk4("ch4.after", 8'b01_11_10_11, 4'b0010, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-stream, then HUNT discards an unsynced beat
    step2(1'b1, 1'b1, 2'b11);
    v2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk2("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk4("async_rst4", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step2(1'b1, 1'b0, 2'b01);
    chk2("post_rst_hunt", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    step2(1'b1, 1'b1, 2'b11);
    chk2("post_rst_lock", 4'b0011, 2'b01, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
